switch_input_ctrl: RTL

Front-end controller for the board's 16 slide switches and the "confirm" push-button. It synchronises and debounces the raw pins and keeps a live switch value. On each confirmed button press it latches a snapshot and raises a status flag. It serves CPU reads from memorio through a chip-select/read/address port with fixed one-cycle latency. It sits between the board pins and memorio, in place of direct pin sampling.

---
 rtl/switch_input_ctrl_if.sv | 25 ++
 rtl/switch_input_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/switch_input_ctrl_if.sv
// Read-port bundle between memorio (master) and the switch input controller (slave).
// memorio drives the chip-select, read strobe and address, and the controller returns data and a valid pulse.
interface switch_input_ctrl_if;
    logic        swcs;
    logic        swread;
    logic [1:0]  swaddr;
    logic [15:0] rdata;
    logic        rvalid;

    modport master (
        output swcs,
        output swread,
        output swaddr,
        input  rdata,
        input  rvalid
    );

    modport slave (
        input  swcs,
        input  swread,
        input  swaddr,
        output rdata,
        output rvalid
    );
endinterface

// File: rtl/switch_input_ctrl.sv
// Synchronises and debounces the 16 slide switches and the confirm button, then snapshots the switches on each press.
// memorio reads the controller through a chip-select/read port, and read data is valid one cycle after the request.
module switch_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int CNT_W           = 18
) (
    input  logic                 ioclk,
    input  logic                 iorst,
    input  logic [15:0]          raw_sw,
    input  logic                 raw_btn,
    switch_input_ctrl_if.slave   bus,
    output logic                 snap_flag
);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [0:0]       BTN_UP   = 1'b0;
    localparam logic [0:0]       BTN_DOWN = 1'b1;

    logic [15:0]      r_swMeta;
    logic [15:0]      r_swSync;
    logic             r_btnMeta;
    logic             r_btnSync;
    logic [15:0]      r_swCand;
    logic [CNT_W-1:0] r_swCnt;
    logic [15:0]      r_swStable;
    logic             r_btnCand;
    logic [CNT_W-1:0] r_btnCnt;
    logic             r_btnStable;
    logic [0:0]       r_btnState;
    logic [15:0]      r_snapshot;
    logic             r_snapFlag;
    logic [15:0]      r_rdata;
    logic             r_rvalid;
    logic             w_read;
    logic             w_press;
    logic [15:0]      w_readData;

    always_ff @(posedge ioclk or negedge iorst) begin
        if (!iorst) begin
            r_swMeta  <= '0;
            r_swSync  <= '0;
            r_btnMeta <= 1'b0;
            r_btnSync <= 1'b0;
        end else begin
            r_swMeta  <= raw_sw;
            r_swSync  <= r_swMeta;
            r_btnMeta <= raw_btn;
            r_btnSync <= r_btnMeta;
        end
    end

    // A change in any bit restarts the window for the whole vector; the counter saturates at the limit.
    always_ff @(posedge ioclk or negedge iorst) begin
        if (!iorst) begin
            r_swCand   <= '0;
            r_swCnt    <= '0;
            r_swStable <= '0;
        end else if (r_swSync != r_swCand) begin
            r_swCand <= r_swSync;
            r_swCnt  <= '0;
        end else if (r_swCnt < CNT_MAX) begin
            r_swCnt <= r_swCnt + 1'b1;
        end else begin
            r_swStable <= r_swCand;
        end
    end

    always_ff @(posedge ioclk or negedge iorst) begin
        if (!iorst) begin
            r_btnCand   <= 1'b0;
            r_btnCnt    <= '0;
            r_btnStable <= 1'b0;
        end else if (r_btnSync != r_btnCand) begin
            r_btnCand <= r_btnSync;
            r_btnCnt  <= '0;
        end else if (r_btnCnt < CNT_MAX) begin
            r_btnCnt <= r_btnCnt + 1'b1;
        end else begin
            r_btnStable <= r_btnCand;
        end
    end

    assign w_press = (r_btnState == BTN_UP) && r_btnStable;
    assign w_read  = bus.swcs && bus.swread;

    // A press only counts on the up-to-down transition, so a held button produces one snapshot.
    always_ff @(posedge ioclk or negedge iorst) begin
        if (!iorst) begin
            r_btnState <= BTN_UP;
            r_snapshot <= '0;
        end else if (w_press) begin
            r_btnState <= BTN_DOWN;
            r_snapshot <= r_swStable;
        end else if ((r_btnState == BTN_DOWN) && !r_btnStable) begin
            r_btnState <= BTN_UP;
        end
    end

    // If a press and a status read land on the same edge, the set wins over the clear.
    always_ff @(posedge ioclk or negedge iorst) begin
        if (!iorst) begin
            r_snapFlag <= 1'b0;
        end else if (w_press) begin
            r_snapFlag <= 1'b1;
        end else if (w_read && (bus.swaddr == 2'b11)) begin
            r_snapFlag <= 1'b0;
        end
    end

    always_comb begin
        w_readData = r_swStable;
        case (bus.swaddr)
            2'b00:   w_readData = r_swStable;
            2'b01:   w_readData = r_snapshot;
            2'b10:   w_readData = {8'h00, r_swStable[15:8]};
            default: w_readData = {15'b0, r_snapFlag};
        endcase
    end

    always_ff @(posedge ioclk or negedge iorst) begin
        if (!iorst) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_read;
            if (w_read) begin
                r_rdata <= w_readData;
            end
        end
    end

    assign bus.rdata  = r_rdata;
    assign bus.rvalid = r_rvalid;
    assign snap_flag  = r_snapFlag;
endmodule
